// File: rtl/fp51_boot_loader_if.sv
// ----------------------------------------------------------------------------
// fp51_boot_loader_if
//   Bus bundle between the FP51 boot loader and its neighbours.
//   - rx_data / rx_valid            : byte stream from the host UART receiver
//   - tx_data / tx_valid / tx_ready : response byte handshake to the UART tx
//   - inst_mem_we / inst_mem_wr_addr / inst_mem_data_in : instruction-memory
//                                     write port driven by the loader
//   modport master : the boot loader side (drives tx and memory write port)
//   modport slave  : the host / memory side
// ----------------------------------------------------------------------------
interface fp51_boot_loader_if #(
    parameter int PC_BITWIDTH = 16
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   inst_mem_we;
    logic [PC_BITWIDTH-3:0] inst_mem_wr_addr;
    logic [31:0]            inst_mem_data_in;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid,
        output inst_mem_we,
        output inst_mem_wr_addr,
        output inst_mem_data_in
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid,
        input  inst_mem_we,
        input  inst_mem_wr_addr,
        input  inst_mem_data_in
    );
endinterface

// File: rtl/fp51_boot_loader.sv
// ----------------------------------------------------------------------------
// fp51_boot_loader
//   Parses framed commands from a host byte stream and loads code into the
//   FP51 instruction memory.
//   Frame: SYNC CMD [ADDR_HI ADDR_LO LEN DATA...] CHK
//     CMD 8'h01 = WRITE (LEN words, 0 means 256, big-endian bytes)
//     CMD 8'h02 = RUN   (releases pause, pulses run_pulse)
//   The checksum is the mod-256 sum of every byte after SYNC including CHK;
//   a frame is good when that sum is zero. Every frame that reaches CHK, or
//   carries an unknown CMD, is answered with ACK_BYTE or NAK_BYTE.
// Ports:
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   bus        : rx byte stream, tx response handshake, imem write port
//   pause      : holds the core stalled (1 out of reset)
//   run_pulse  : one-cycle run strobe to the core
//   busy       : high whenever the parser is not idle
// ----------------------------------------------------------------------------
module fp51_boot_loader #(
    parameter int         PC_BITWIDTH    = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'h5A,
    parameter logic [7:0] ACK_BYTE       = 8'hA5,
    parameter logic [7:0] NAK_BYTE       = 8'hEE,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    fp51_boot_loader_if.master      bus,
    output logic                    pause,
    output logic                    run_pulse,
    output logic                    busy
);
    localparam int AW = PC_BITWIDTH - 2;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] ADDR_HI = 3'd2;
    localparam logic [2:0] ADDR_LO = 3'd3;
    localparam logic [2:0] LEN     = 3'd4;
    localparam logic [2:0] DATA    = 3'd5;
    localparam logic [2:0] CHK     = 3'd6;
    localparam logic [2:0] RESP    = 3'd7;

    logic [2:0]    state;
    logic [7:0]    chk_sum;
    logic          is_run;
    logic [7:0]    addr_hi;
    logic [AW-1:0] wr_ptr;
    logic [8:0]    words_left;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic          we_q;
    logic [AW-1:0] wr_addr_q;
    logic [31:0]   wr_data_q;
    logic          in_frame;
    logic          timed_out;

    assign bus.tx_data          = tx_data_q;
    assign bus.tx_valid         = tx_valid_q;
    assign bus.inst_mem_we      = we_q;
    assign bus.inst_mem_wr_addr = wr_addr_q;
    assign bus.inst_mem_data_in = wr_data_q;

    always_comb begin
        busy      = (state != IDLE);
        in_frame  = (state != IDLE) && (state != RESP);
        // A byte arriving on the limit cycle still counts as activity.
        timed_out = in_frame && !bus.rx_valid &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            chk_sum    <= '0;
            is_run     <= 1'b0;
            addr_hi    <= '0;
            wr_ptr     <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            tmo_cnt    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            pause      <= 1'b1;
            run_pulse  <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            run_pulse <= 1'b0;

            if (timed_out) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                if (in_frame) begin
                    tmo_cnt <= bus.rx_valid ? '0 : tmo_cnt + TW'(1);
                    if (bus.rx_valid)
                        chk_sum <= chk_sum + bus.rx_data;
                end

                case (state)
                    IDLE: begin
                        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                            chk_sum <= '0;
                            tmo_cnt <= '0;
                            state   <= CMD;
                        end
                    end
                    CMD: begin
                        if (bus.rx_valid) begin
                            case (bus.rx_data)
                                8'h01: begin
                                    is_run <= 1'b0;
                                    state  <= ADDR_HI;
                                end
                                8'h02: begin
                                    is_run <= 1'b1;
                                    state  <= CHK;
                                end
                                default: begin
                                    tx_data_q  <= NAK_BYTE;
                                    tx_valid_q <= 1'b1;
                                    state      <= RESP;
                                end
                            endcase
                        end
                    end
                    ADDR_HI: begin
                        if (bus.rx_valid) begin
                            addr_hi <= bus.rx_data;
                            state   <= ADDR_LO;
                        end
                    end
                    ADDR_LO: begin
                        if (bus.rx_valid) begin
                            wr_ptr <= AW'({addr_hi, bus.rx_data});
                            state  <= LEN;
                        end
                    end
                    LEN: begin
                        if (bus.rx_valid) begin
                            words_left <= (bus.rx_data == 8'h00) ? 9'd256
                                                                  : {1'b0, bus.rx_data};
                            byte_cnt   <= '0;
                            pause      <= 1'b1;
                            state      <= DATA;
                        end
                    end
                    DATA: begin
                        if (bus.rx_valid) begin
                            shift    <= {shift[15:0], bus.rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                we_q      <= 1'b1;
                                wr_addr_q <= wr_ptr;
                                wr_data_q <= {shift, bus.rx_data};
                                wr_ptr    <= wr_ptr + AW'(1);
                                if (words_left == 9'd1)
                                    state <= CHK;
                                else
                                    words_left <= words_left - 9'd1;
                            end
                        end
                    end
                    CHK: begin
                        if (bus.rx_valid) begin
                            if (chk_sum + bus.rx_data == 8'h00) begin
                                tx_data_q <= ACK_BYTE;
                                if (is_run) begin
                                    pause     <= 1'b0;
                                    run_pulse <= 1'b1;
                                end
                            end else begin
                                tx_data_q <= NAK_BYTE;
                            end
                            tx_valid_q <= 1'b1;
                            state      <= RESP;
                        end
                    end
                    RESP: begin
                        if (tx_valid_q && bus.tx_ready) begin
                            tx_valid_q <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fp51_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_fp51_boot_loader
//   Directed and randomized frames against a frame-level reference model:
//   expected writes are (base + i) mod 2^14 / word i, expected response is
//   ACK for a zero checksum sum and NAK otherwise, pause tracked per frame.
// ----------------------------------------------------------------------------
module tb_fp51_boot_loader;
    localparam int PCW = 16;
    localparam int AW  = PCW - 2;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pause, run_pulse, busy;

    fp51_boot_loader_if #(.PC_BITWIDTH(PCW)) bus_if ();

    fp51_boot_loader #(
        .PC_BITWIDTH(PCW),
        .SYNC_BYTE(8'h5A),
        .ACK_BYTE(8'hA5),
        .NAK_BYTE(8'hEE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if),
        .pause(pause),
        .run_pulse(run_pulse),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [AW+31:0] obs_q[$];
    int run_cnt = 0;
    logic pause_exp = 1'b1;
    logic [31:0] words_q[$];

    // Every write strobe and run strobe seen, one entry per high cycle.
    always @(negedge clk) begin
        if (bus_if.inst_mem_we === 1'b1)
            obs_q.push_back({bus_if.inst_mem_wr_addr, bus_if.inst_mem_data_in});
        if (run_pulse === 1'b1)
            run_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic finish_resp(input logic [7:0] exp, input int hold);
        check("tx_valid_latency", bus_if.tx_valid, 1);
        check("tx_data", bus_if.tx_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("tx_hold", {bus_if.tx_valid, bus_if.tx_data}, {1'b1, exp});
        end
        bus_if.tx_ready = 1'b1;
        @(negedge clk);
        bus_if.tx_ready = 1'b0;
        check("tx_done_busy", {bus_if.tx_valid, busy}, 0);
        check("pause", pause, pause_exp);
    endtask

    // WRITE frame of words_q; len_field 0 means 256 words.
    task automatic do_write(input logic [15:0] base, input int len_field,
                            input bit corrupt, input int gmax);
        int n;
        logic [7:0] sum;
        logic [7:0] b;
        logic [7:0] chk;
        logic [31:0] wd;
        logic [AW-1:0] a;
        n = (len_field == 0) ? 256 : len_field;
        obs_q.delete();
        sum = 8'h01 + base[15:8] + base[7:0] + 8'(len_field);
        send_byte(8'h5A);
        idle($urandom_range(0, gmax));
        send_byte(8'h01);
        send_byte(base[15:8]);
        idle($urandom_range(0, gmax));
        send_byte(base[7:0]);
        send_byte(8'(len_field));
        pause_exp = 1'b1;
        check("pause_after_len", {pause, busy}, 2'b11);
        for (int w = 0; w < n; w++) begin
            wd = words_q[w];
            for (int k = 0; k < 4; k++) begin
                b = wd[31-8*k -: 8];
                sum = sum + b;
                idle($urandom_range(0, gmax));
                send_byte(b);
            end
            a = AW'((int'(base) + w) % (1 << AW));
            check("we_latency", bus_if.inst_mem_we, 1);
            check("wr_addr", bus_if.inst_mem_wr_addr, a);
            check("wr_data", bus_if.inst_mem_data_in, wd);
        end
        chk = 8'(0) - sum;
        if (corrupt)
            chk = chk + 8'($urandom_range(1, 255));
        idle($urandom_range(0, gmax));
        send_byte(chk);
        finish_resp(corrupt ? 8'hEE : 8'hA5, 0);
        check("write_count", obs_q.size(), n);
    endtask

    task automatic do_run(input bit corrupt, input int hold);
        logic [7:0] chk;
        obs_q.delete();
        run_cnt = 0;
        chk = corrupt ? 8'(8'hFE + $urandom_range(1, 255)) : 8'hFE;
        send_byte(8'h5A);
        send_byte(8'h02);
        send_byte(chk);
        if (!corrupt)
            pause_exp = 1'b0;
        check("run_pulse", run_pulse, corrupt ? 0 : 1);
        check("run_pause", pause, pause_exp);
        finish_resp(corrupt ? 8'hEE : 8'hA5, hold);
        check("run_count", run_cnt, corrupt ? 0 : 1);
        check("run_no_write", obs_q.size(), 0);
    endtask

    task automatic do_badcmd(input logic [7:0] cmd);
        obs_q.delete();
        send_byte(8'h5A);
        send_byte(cmd);
        finish_resp(8'hEE, 0);
        check("badcmd_no_write", obs_q.size(), 0);
    endtask

    initial begin
        int k;
        int kind;
        logic [7:0] cmd;
        bus_if.rx_data  = '0;
        bus_if.rx_valid = 1'b0;
        bus_if.tx_ready = 1'b0;

        // Reset values
        idle(3);
        check("reset_pause", pause, 1);
        reset_n = 1'b1;
        idle(1);
        check("reset_pause_rel", pause, 1);
        check("reset_strobes", {busy, bus_if.tx_valid, bus_if.inst_mem_we, run_pulse}, 0);
        check("reset_tx_data", bus_if.tx_data, 0);
        check("reset_wr_addr", bus_if.inst_mem_wr_addr, 0);
        check("reset_wr_data", bus_if.inst_mem_data_in, 0);

        // Non-SYNC bytes in IDLE are ignored
        obs_q.delete();
        send_byte(8'h00);
        send_byte(8'h33);
        idle(2);
        check("idle_garbage", {busy, bus_if.tx_valid}, 0);
        check("idle_no_write", obs_q.size(), 0);

        // Directed two-word write, good then bad checksum
        words_q = '{32'h11223344, 32'h55667788};
        do_write(16'h0010, 2, 1'b0, 0);
        do_write(16'h0010, 2, 1'b1, 0);

        // RUN with delayed tx_ready
        do_run(1'b0, 10);

        // Wrap at the top of the word address space; a SYNC value as data
        words_q = '{32'h5A5A5A5A, 32'hDEADBEEF};
        do_write(16'h3FFF, 2, 1'b0, 1);
        check("pause_relatched", pause, 1);

        // Unknown command
        do_badcmd(8'h07);

        // Randomized frames
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                words_q.delete();
                k = $urandom_range(1, 4);
                for (int w = 0; w < k; w++)
                    words_q.push_back($urandom);
                do_write(16'($urandom), k, ($urandom_range(0, 3) == 0), 3);
            end else if (kind == 2) begin
                do_run($urandom_range(0, 2) == 0, $urandom_range(0, 3));
            end else begin
                cmd = 8'($urandom_range(3, 255));
                do_badcmd(cmd);
            end
        end

        // LEN = 0 writes 256 words
        words_q.delete();
        for (int w = 0; w < 256; w++)
            words_q.push_back($urandom);
        do_write(16'($urandom), 0, 1'b0, 0);

        // Timeout mid-frame: no response, no write, pause unchanged
        do_run(1'b0, 0);
        obs_q.delete();
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h00);
        idle(TMO - 5);
        check("timeout_still_busy", busy, 1);
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("timeout_busy", busy, 0);
        check("timeout_no_tx", bus_if.tx_valid, 0);
        check("timeout_no_write", obs_q.size(), 0);
        check("timeout_pause", pause, pause_exp);

        // Reset asserted while a write strobe is high
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'hC0);
        send_byte(8'hFF);
        send_byte(8'hEE);
        send_byte(8'h01);
        check("pre_reset_we", bus_if.inst_mem_we, 1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_we", bus_if.inst_mem_we, 0);
        check("reset_mid_pause", pause, 1);
        check("reset_mid_busy", {busy, bus_if.tx_valid}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pause_exp = 1'b1;
        idle(1);

        // Recovery after reset
        words_q = '{32'h0BADF00D};
        do_write(16'h0100, 1, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
